line8_pulse_decoder: RTL and testbench

//  Inverse of the 8-line priority encoder: accepts a 4-bit binary line code (s4..s1) and

---
 rtl/line8_pulse_decoder.sv | 113 +++++++++++
 tb/tb_line8_pulse_decoder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/line8_pulse_decoder.sv
`default_nettype none
// ============================================================================
// Module      : line8_pulse_decoder
// Description : Decodes a 4-bit line code into a timed one-hot pulse on one
//               of eight output lines, followed by an optional idle gap.
//               Code 15 is a silent no-op; codes 8..14 raise a one-cycle err.
// Revision    : 1.0 - initial release
// ============================================================================
module line8_pulse_decoder #(
    parameter int unsigned PULSE_LEN = 4,
    parameter int unsigned GAP_LEN   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] code,
    output logic [7:0] e,
    output logic       busy,
    output logic       err
);

    // Reject parameter values the 8-bit down-counter cannot represent.
    generate
        if (PULSE_LEN < 1 || PULSE_LEN > 255) begin : g_bad_pulse_len
            $error("line8_pulse_decoder: PULSE_LEN must be in 1..255");
        end
        if (GAP_LEN > 255) begin : g_bad_gap_len
            $error("line8_pulse_decoder: GAP_LEN must be in 0..255");
        end
    endgenerate

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    // Counter loads are always length-1 so the terminal count is zero.
    localparam logic [7:0] c_pulse_load = 8'(PULSE_LEN - 1);
    localparam logic [7:0] c_gap_load   = 8'(GAP_LEN - 1);
    localparam logic [3:0] c_code_none  = 4'hF;

    logic [1:0] r_state;
    logic [7:0] r_cnt;
    logic [7:0] r_e;
    logic       r_busy;
    logic       r_err;
    logic       w_accept;

    // Ready is a pure decode of the state, forced low while reset is held.
    assign in_ready = (r_state == S_IDLE) && rst_n;
    assign w_accept = in_valid && (r_state == S_IDLE);

    assign e    = r_e;
    assign busy = r_busy;
    assign err  = r_err;

    // Pulse sequencer: IDLE accepts a code, DRIVE holds the line, GAP idles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_e     <= 8'h00;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (!code[3]) begin
                            r_e     <= 8'b1 << code[2:0];
                            r_cnt   <= c_pulse_load;
                            r_state <= S_DRIVE;
                            r_busy  <= 1'b1;
                        end else if (code != c_code_none) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_DRIVE: begin
                    if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else begin
                        r_e <= 8'h00;
                        if (GAP_LEN > 0) begin
                            r_cnt   <= c_gap_load;
                            r_state <= S_GAP;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                S_GAP: begin
                    if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 8'd0;
                    r_e     <= 8'h00;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_line8_pulse_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_line8_pulse_decoder
// Description : Self-checking bench for line8_pulse_decoder. Instance 0 uses
//               the default lengths (4/1), instance 1 uses 1/0. A cycle model
//               predicts ready/busy/err/drive timing; expected line values
//               are queued on acceptance and popped when a pulse starts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line8_pulse_decoder;

    localparam int c_p0 = 4;
    localparam int c_g0 = 1;
    localparam int c_p1 = 1;
    localparam int c_g1 = 0;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      in_valid = 2'b00;
    logic [1:0][3:0] code = '0;
    logic [1:0]      in_ready;
    logic [1:0][7:0] e;
    logic [1:0]      busy;
    logic [1:0]      err;

    int n_checks = 0;
    int n_pass   = 0;

    // Bench model state
    int         cyc = 0;
    int         m_left [2];
    logic       m_err  [2];
    int         m_acc  [2];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] prev_e [2];

    line8_pulse_decoder #(.PULSE_LEN(c_p0), .GAP_LEN(c_g0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .code(code[0]), .e(e[0]), .busy(busy[0]), .err(err[0])
    );

    line8_pulse_decoder #(.PULSE_LEN(c_p1), .GAP_LEN(c_g1)) dut_short (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .code(code[1]), .e(e[1]), .busy(busy[1]), .err(err[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                      tag, got, got, exp, exp, $time);
    endtask

    function automatic int plen(input int i);
        return (i == 0) ? c_p0 : c_p1;
    endfunction

    function automatic int glen(input int i);
        return (i == 0) ? c_g0 : c_g1;
    endfunction

    // Cycle model: acceptance, busy window and err pulse; pushes expected lines
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_left[i] <= 0;
                m_err[i]  <= 1'b0;
            end
            q0.delete();
            q1.delete();
        end else begin
            cyc <= cyc + 1;
            for (int i = 0; i < 2; i++) begin
                m_err[i] <= 1'b0;
                if (m_left[i] == 0) begin
                    if (in_valid[i]) begin
                        m_acc[i] <= m_acc[i] + 1;
                        if (code[i] < 4'd8) begin
                            m_left[i] <= plen(i) + glen(i);
                            if (i == 0) q0.push_back(8'd1 << code[i][2:0]);
                            else        q1.push_back(8'd1 << code[i][2:0]);
                        end else if (code[i] != 4'hF) begin
                            m_err[i] <= 1'b1;
                        end
                    end
                end else begin
                    m_left[i] <= m_left[i] - 1;
                end
            end
        end
    end

    // Monitor on the falling edge: compare every output against the model
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            automatic int qs = (i == 0) ? q0.size() : q1.size();
            automatic logic [7:0] exp_e;
            chk($sformatf("in_ready%0d", i), int'(in_ready[i]), int'(rst_n && m_left[i] == 0));
            chk($sformatf("busy%0d", i), int'(busy[i]), int'(m_left[i] != 0));
            chk($sformatf("err%0d", i), int'(err[i]), int'(m_err[i]));
            chk($sformatf("drive%0d", i), int'(e[i] != 8'h00), int'(m_left[i] > glen(i)));
            chk($sformatf("onehot%0d", i), int'($onehot0(e[i])), 1);
            if (e[i] != 8'h00 && prev_e[i] == 8'h00) begin
                chk($sformatf("sb_avail%0d", i), int'(qs > 0), 1);
                if (qs > 0) begin
                    exp_e = (i == 0) ? q0.pop_front() : q1.pop_front();
                    chk($sformatf("sb_line%0d", i), int'(e[i]), int'(exp_e));
                end
            end else if (e[i] != 8'h00) begin
                chk($sformatf("hold%0d", i), int'(e[i]), int'(prev_e[i]));
            end
            prev_e[i] = e[i];
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a code and keep it up until the model records an acceptance.
    task automatic send(input int i, input logic [3:0] c, output int when);
        int start;
        int n;
        start = m_acc[i];
        in_valid[i] = 1'b1;
        code[i] = c;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (m_acc[i] == start && n < 50);
        chk($sformatf("accept_timeout%0d", i), int'(m_acc[i] != start), 1);
        when = cyc;
    endtask

    task automatic wait_ready(input int i);
        int n;
        n = 0;
        while (!in_ready[i] && n < 50) begin
            tick(1);
            n++;
        end
        chk($sformatf("ready_timeout%0d", i), int'(in_ready[i]), 1);
    endtask

    initial begin
        int t;
        int tprev;
        for (int i = 0; i < 2; i++) begin
            m_acc[i]  = 0;
            prev_e[i] = 8'h00;
        end

        // 1: reset held with a valid code presented
        in_valid[0] = 1'b1;
        code[0] = 4'd3;
        tick(3);
        chk("rst_e", int'(e[0]), 0);
        chk("rst_ready", int'(in_ready[0]), 0);
        chk("rst_busy", int'(busy[0]), 0);
        chk("rst_err", int'(err[0]), 0);
        in_valid[0] = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rel_ready", int'(in_ready[0]), 1);
        tick(1);

        // 2: single pulses on e1 and e8 with default lengths
        send(0, 4'd0, t);
        in_valid[0] = 1'b0;
        chk("e1_line", int'(e[0]), 8'h01);
        wait_ready(0);
        send(0, 4'd7, t);
        in_valid[0] = 1'b0;
        chk("e8_line", int'(e[0]), 8'h80);
        wait_ready(0);
        tick(1);

        // 3: back-to-back sweep with in_valid held high
        tprev = 0;
        for (int c = 0; c < 8; c++) begin
            send(0, 4'(c), t);
            if (c > 0) chk("sweep_spacing", t - tprev, c_p0 + c_g0 + 1);
            tprev = t;
        end
        in_valid[0] = 1'b0;
        wait_ready(0);
        tick(1);

        // 4: no-op code then an illegal code
        send(0, 4'hF, t);
        in_valid[0] = 1'b0;
        chk("none_ready", int'(in_ready[0]), 1);
        chk("none_err", int'(err[0]), 0);
        send(0, 4'd9, t);
        in_valid[0] = 1'b0;
        chk("illegal_err", int'(err[0]), 1);
        chk("illegal_e", int'(e[0]), 0);
        tick(1);
        chk("illegal_err_drop", int'(err[0]), 0);

        // 5: asynchronous reset in the middle of a pulse
        send(0, 4'd5, t);
        in_valid[0] = 1'b0;
        tick(1);
        chk("mid_e", int'(e[0]), 8'h20);
        rst_n = 1'b0;
        #1;
        chk("async_e", int'(e[0]), 0);
        chk("async_busy", int'(busy[0]), 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        send(0, 4'd3, t);
        in_valid[0] = 1'b0;
        chk("post_rst_e", int'(e[0]), 8'h08);
        wait_ready(0);

        // 6: short instance, pulse of one cycle and no gap
        send(1, 4'd2, tprev);
        chk("short_e", int'(e[1]), 8'h04);
        chk("short_ready", int'(in_ready[1]), 0);
        send(1, 4'd6, t);
        in_valid[1] = 1'b0;
        chk("short_spacing", t - tprev, 2);
        chk("short_e2", int'(e[1]), 8'h40);
        tick(1);
        chk("short_e_off", int'(e[1]), 0);
        wait_ready(1);
        tick(2);

        chk("sb_empty", q0.size() + q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
